clken_gen: RTL

//  Parametrised clock-enable and reset-sequencing generator in the clk32 domain.

---
 rtl/clken_gen_if.sv | 37 +++
 rtl/clken_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/clken_gen_if.sv
// Signal bundle between clken_gen and its environment.
// The lock-loss counter pair exists only when CLKEN_LOCKLOSS_CNT_EN is defined.
interface clken_gen_if #(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 5
);
  logic                        lock_in;
  logic [NUM_CH*PHASE_W-1:0]   phase_cfg;
  logic [NUM_CH-1:0]           ch_mask;
  logic                        rst_out;
  logic                        running;
  logic [PHASE_W-1:0]          cycle_cnt;
  logic                        phi2;
  logic [NUM_CH-1:0]           ce;
`ifdef CLKEN_LOCKLOSS_CNT_EN
  logic [7:0]                  lock_loss_cnt;
  logic                        lock_loss_clr;

  modport master (
    output lock_in, phase_cfg, ch_mask, lock_loss_clr,
    input  rst_out, running, cycle_cnt, phi2, ce, lock_loss_cnt
  );
  modport slave (
    input  lock_in, phase_cfg, ch_mask, lock_loss_clr,
    output rst_out, running, cycle_cnt, phi2, ce, lock_loss_cnt
  );
`else
  modport master (
    output lock_in, phase_cfg, ch_mask,
    input  rst_out, running, cycle_cnt, phi2, ce
  );
  modport slave (
    input  lock_in, phase_cfg, ch_mask,
    output rst_out, running, cycle_cnt, phi2, ce
  );
`endif
endinterface

// File: rtl/clken_gen.sv
// Clock-enable and reset sequencer: PLL lock qualification, stretched reset, period counter
// with per-channel enable strobes and phi2. Optional lock-loss counter: CLKEN_LOCKLOSS_CNT_EN.
module clken_gen #(
  parameter int DIV      = 32,
  parameter int NUM_CH   = 4,
  parameter int PHASE_W  = 5,
  parameter int RST_HOLD = 16
) (
  input  logic       clk32,
  input  logic       reset,
  clken_gen_if.slave bus
);

  typedef enum logic [1:0] {ST_WAIT_LOCK = 2'd0, ST_HOLD = 2'd1, ST_RUN = 2'd2} state_t;

  localparam logic [PHASE_W-1:0] LP_CNT_LAST  = PHASE_W'(DIV - 1);
  localparam logic [PHASE_W-1:0] LP_CNT_ONE   = PHASE_W'(1);
  localparam logic [PHASE_W:0]   LP_HALF      = (PHASE_W + 1)'(DIV / 2);
  localparam logic [7:0]         LP_HOLD_LAST = 8'(RST_HOLD - 1);

  state_t                      r_state;
  logic                        r_sync1;
  logic                        r_lock_s;
  logic [7:0]                  r_hold;
  logic [PHASE_W-1:0]          r_cnt;
  logic [NUM_CH*PHASE_W-1:0]   r_sh_phase;
  logic [NUM_CH-1:0]           r_sh_mask;
  logic                        r_rst_out;
  logic                        r_running;
  logic                        r_phi2;
  logic [NUM_CH-1:0]           r_ce;

  state_t                      w_state_nxt;
  logic [7:0]                  w_hold_nxt;
  logic [PHASE_W-1:0]          w_cnt_nxt;
  logic                        w_load;
  logic [NUM_CH*PHASE_W-1:0]   w_phase_nxt;
  logic [NUM_CH-1:0]           w_mask_nxt;
  logic                        w_run_nxt;
  logic [NUM_CH-1:0]           w_ce_nxt;
  logic                        w_phi2_nxt;

  // Lock synchroniser
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= bus.lock_in;
      r_lock_s <= r_sync1;
    end
  end

  // Next state plus next output values; outputs are registered from these so that
  // ce, phi2 and cycle_cnt all change on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_cnt_nxt   = '0;
    w_load      = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = 8'd0;
        end else begin
          w_state_nxt = ST_WAIT_LOCK;
        end
      end
      ST_HOLD: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_hold == LP_HOLD_LAST) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else begin
          w_hold_nxt  = r_hold + 8'd1;
        end
      end
      ST_RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_load      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + LP_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
      end
    endcase

    // Shadow config is swapped only at period boundaries (and on entry into RUN).
    if (w_load) begin
      w_phase_nxt = bus.phase_cfg;
      w_mask_nxt  = bus.ch_mask;
    end else begin
      w_phase_nxt = r_sh_phase;
      w_mask_nxt  = r_sh_mask;
    end

    w_run_nxt  = (w_state_nxt == ST_RUN);
    w_phi2_nxt = w_run_nxt && ({1'b0, w_cnt_nxt} >= LP_HALF);
    w_ce_nxt   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ce_nxt[i] = w_run_nxt && w_mask_nxt[i] &&
                    (w_phase_nxt[i*PHASE_W +: PHASE_W] == w_cnt_nxt);
    end
  end

  // State, counters, shadow config and registered outputs
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      r_state    <= ST_WAIT_LOCK;
      r_hold     <= 8'd0;
      r_cnt      <= '0;
      r_sh_phase <= '0;
      r_sh_mask  <= '0;
      r_rst_out  <= 1'b1;
      r_running  <= 1'b0;
      r_phi2     <= 1'b0;
      r_ce       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sh_phase <= w_phase_nxt;
      r_sh_mask  <= w_mask_nxt;
      r_rst_out  <= !w_run_nxt;
      r_running  <= w_run_nxt;
      r_phi2     <= w_phi2_nxt;
      r_ce       <= w_ce_nxt;
    end
  end

  assign bus.rst_out   = r_rst_out;
  assign bus.running   = r_running;
  assign bus.cycle_cnt = r_cnt;
  assign bus.phi2      = r_phi2;
  assign bus.ce        = r_ce;

`ifdef CLKEN_LOCKLOSS_CNT_EN
  logic [7:0] r_loss_cnt;
  logic       w_loss;

  // A lock drop is only meaningful once the sequence has left WAIT_LOCK.
  assign w_loss = !r_lock_s && ((r_state == ST_HOLD) || (r_state == ST_RUN));

  // Saturating lock-loss counter, clear wins over increment
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      r_loss_cnt <= 8'd0;
    end else if (bus.lock_loss_clr) begin
      r_loss_cnt <= 8'd0;
    end else if (w_loss && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end else begin
      r_loss_cnt <= r_loss_cnt;
    end
  end

  assign bus.lock_loss_cnt = r_loss_cnt;
`endif

endmodule
